// File: rtl/addr_xlate_unit_pkg.sv
// Shared definitions for the address translation front end.
// Holds request op encodings, exception codes, DMW CSR field positions,
// the front-end state enum and a small DMW match helper.
package addr_xlate_unit_pkg;

    // Request operation encodings (req_op)
    localparam logic [1:0] OP_FETCH = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    // Exception codes reported on resp_ecode
    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;

    // Huge-page size as reported by the TLB; anything else is treated as 4KB
    localparam logic [5:0] PS_2M = 6'd21;

    // DMW CSR field positions
    localparam int unsigned DMW_PLV0_BIT = 0;
    localparam int unsigned DMW_PLV3_BIT = 3;
    localparam int unsigned DMW_MAT_LSB  = 4;
    localparam int unsigned DMW_PSEG_LSB = 25;
    localparam int unsigned DMW_VSEG_LSB = 29;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StResp
    } state_e;

    // A window only matches at PLV0 or PLV3, and only if that level's enable bit is set.
    function automatic logic dmw_match(input logic [2:0] vseg, input logic plv0_en,
                                       input logic plv3_en, input logic [2:0] va_seg,
                                       input logic [1:0] plv);
        logic plv_ok;
        plv_ok = ((plv == 2'd0) && plv0_en) || ((plv == 2'd3) && plv3_en);
        return plv_ok && (va_seg == vseg);
    endfunction

endpackage

// File: rtl/addr_xlate_unit_xlate_check.sv
// Combinational TLB result checker: forms the physical address from the TLB
// entry and the page offset, and picks the highest-priority exception.
// Ports:
//   voff      in  21  vaddr[20:0] of the registered request
//   op        in  2   registered request op
//   plv       in  2   registered CRMD.PLV
//   tlb_*     in      TLB search outputs
//   paddr     out 32  translated physical address (driven even on exception)
//   mat       out 2   entry MAT
//   ex        out 1   exception flag
//   ecode     out 6   exception code, 0 when ex=0
module addr_xlate_unit_xlate_check
    import addr_xlate_unit_pkg::*;
(
    input  logic [20:0] voff,
    input  logic [1:0]  op,
    input  logic [1:0]  plv,
    input  logic        tlb_found,
    input  logic [5:0]  tlb_ps,
    input  logic [19:0] tlb_ppn,
    input  logic        tlb_v,
    input  logic        tlb_d,
    input  logic [1:0]  tlb_mat,
    input  logic [1:0]  tlb_plv,
    output logic [31:0] paddr,
    output logic [1:0]  mat,
    output logic        ex,
    output logic [5:0]  ecode
);

    always_comb begin
        if (tlb_ps == PS_2M) begin
            paddr = {tlb_ppn[19:9], voff};
        end else begin
            paddr = {tlb_ppn, voff[11:0]};
        end
        mat   = tlb_mat;
        ex    = 1'b1;
        ecode = 6'h00;

        if (!tlb_found) begin
            ecode = ECODE_TLBR;
        end else if (!tlb_v) begin
            case (op)
                OP_FETCH: ecode = ECODE_PIF;
                OP_STORE: ecode = ECODE_PIS;
                default:  ecode = ECODE_PIL;
            endcase
        end else if (plv > tlb_plv) begin
            ecode = ECODE_PPI;
        end else if ((op == OP_STORE) && !tlb_d) begin
            ecode = ECODE_PME;
        end else begin
            ex = 1'b0;
        end
    end

endmodule

// File: rtl/addr_xlate_unit.sv
// Data-side virtual-to-physical translation front end.
// Resolves each request by DA mode, DMW hit or TLB lookup (in that order) and
// returns paddr/MAT/exception over a valid/ready response channel.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/ready/vaddr/op request channel
//   resp_valid/ready/paddr/mat/ex/ecode  response channel
//   flush                   abort any in-flight request
//   csr_*                   CRMD / ASID / DMW0 / DMW1 CSR values
//   tlb_fetch/vppn/odd_page/asid   TLB search port request
//   tlb_found..tlb_plv      TLB search results, valid the cycle after tlb_fetch
module addr_xlate_unit
    import addr_xlate_unit_pkg::*;
#(
    parameter int unsigned TLBNUM = 8,
    parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_vaddr,
    input  logic [1:0]      req_op,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_paddr,
    output logic [1:0]      resp_mat,
    output logic            resp_ex,
    output logic [5:0]      resp_ecode,
    input  logic            flush,
    input  logic            csr_da,
    input  logic            csr_pg,
    input  logic [1:0]      csr_plv,
    input  logic [1:0]      csr_datm,
    input  logic [9:0]      csr_asid,
    input  logic [31:0]     csr_dmw0,
    input  logic [31:0]     csr_dmw1,
    output logic            tlb_fetch,
    output logic [18:0]     tlb_vppn,
    output logic            tlb_odd_page,
    output logic [9:0]      tlb_asid,
    input  logic            tlb_found,
    input  logic [IDXW-1:0] tlb_index,
    input  logic [5:0]      tlb_ps,
    input  logic [19:0]     tlb_ppn,
    input  logic            tlb_v,
    input  logic            tlb_d,
    input  logic [1:0]      tlb_mat,
    input  logic [1:0]      tlb_plv
);

    state_e      state_q, state_d;
    logic [20:0] voff_q;
    logic [1:0]  op_q;
    logic [1:0]  plv_q;
    logic [31:0] paddr_q, paddr_d;
    logic [1:0]  mat_q, mat_d;
    logic        ex_q, ex_d;
    logic [5:0]  ecode_q, ecode_d;

    logic        dmw0_hit, dmw1_hit;
    logic [31:0] chk_paddr;
    logic [1:0]  chk_mat;
    logic        chk_ex;
    logic [5:0]  chk_ecode;

    // Index is for debug only; reserved DMW bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{tlb_index, csr_dmw0[28], csr_dmw0[24:6], csr_dmw0[2:1],
                           csr_dmw1[28], csr_dmw1[24:6], csr_dmw1[2:1]};

    assign dmw0_hit = csr_pg && dmw_match(csr_dmw0[DMW_VSEG_LSB +: 3], csr_dmw0[DMW_PLV0_BIT],
                                          csr_dmw0[DMW_PLV3_BIT], req_vaddr[31:29], csr_plv);
    assign dmw1_hit = csr_pg && dmw_match(csr_dmw1[DMW_VSEG_LSB +: 3], csr_dmw1[DMW_PLV0_BIT],
                                          csr_dmw1[DMW_PLV3_BIT], req_vaddr[31:29], csr_plv);

    // Search port is driven straight from the request so the TLB sees it in the accept cycle.
    assign tlb_vppn     = req_vaddr[31:13];
    assign tlb_odd_page = req_vaddr[12];
    assign tlb_asid     = csr_asid;

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_paddr = paddr_q;
    assign resp_mat   = mat_q;
    assign resp_ex    = ex_q;
    assign resp_ecode = ecode_q;

    addr_xlate_unit_xlate_check u_xlate_check (
        .voff      (voff_q),
        .op        (op_q),
        .plv       (plv_q),
        .tlb_found (tlb_found),
        .tlb_ps    (tlb_ps),
        .tlb_ppn   (tlb_ppn),
        .tlb_v     (tlb_v),
        .tlb_d     (tlb_d),
        .tlb_mat   (tlb_mat),
        .tlb_plv   (tlb_plv),
        .paddr     (chk_paddr),
        .mat       (chk_mat),
        .ex        (chk_ex),
        .ecode     (chk_ecode)
    );

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        mat_d     = mat_q;
        ex_d      = ex_q;
        ecode_d   = ecode_q;
        tlb_fetch = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && !flush) begin
                    if (csr_da) begin
                        state_d = StResp;
                        paddr_d = req_vaddr;
                        mat_d   = csr_datm;
                        ex_d    = 1'b0;
                        ecode_d = 6'h00;
                    end else if (dmw0_hit) begin
                        state_d = StResp;
                        paddr_d = {csr_dmw0[DMW_PSEG_LSB +: 3], req_vaddr[28:0]};
                        mat_d   = csr_dmw0[DMW_MAT_LSB +: 2];
                        ex_d    = 1'b0;
                        ecode_d = 6'h00;
                    end else if (dmw1_hit) begin
                        state_d = StResp;
                        paddr_d = {csr_dmw1[DMW_PSEG_LSB +: 3], req_vaddr[28:0]};
                        mat_d   = csr_dmw1[DMW_MAT_LSB +: 2];
                        ex_d    = 1'b0;
                        ecode_d = 6'h00;
                    end else begin
                        state_d   = StLookup;
                        tlb_fetch = 1'b1;
                    end
                end
            end
            StLookup: begin
                state_d = StResp;
                paddr_d = chk_paddr;
                mat_d   = chk_mat;
                ex_d    = chk_ex;
                ecode_d = chk_ecode;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush beats any handshake; the pending result is simply dropped.
        if (flush) begin
            state_d = StIdle;
        end
        if (reset) begin
            tlb_fetch = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            voff_q  <= '0;
            op_q    <= '0;
            plv_q   <= '0;
            paddr_q <= '0;
            mat_q   <= '0;
            ex_q    <= 1'b0;
            ecode_q <= '0;
        end else begin
            state_q <= state_d;
            paddr_q <= paddr_d;
            mat_q   <= mat_d;
            ex_q    <= ex_d;
            ecode_q <= ecode_d;
            // Last capture while idle is the accept cycle; later CSR changes are ignored.
            if (state_q == StIdle) begin
                voff_q <= req_vaddr[20:0];
                op_q   <= req_op;
                plv_q  <= csr_plv;
            end
        end
    end

endmodule

// File: tb/tb_addr_xlate_unit.sv
// Scoreboard bench for addr_xlate_unit: expected responses are queued when a
// request is driven and compared when the response handshake is observed.
module tb_addr_xlate_unit;
    import addr_xlate_unit_pkg::*;

    localparam int unsigned TLBNUM = 8;
    localparam int unsigned IDXW   = 3;

    typedef struct packed {
        logic [31:0] paddr;
        logic [1:0]  mat;
        logic        ex;
        logic [5:0]  ecode;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [31:0]     req_vaddr = '0;
    logic [1:0]      req_op = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [31:0]     resp_paddr;
    logic [1:0]      resp_mat;
    logic            resp_ex;
    logic [5:0]      resp_ecode;
    logic            flush = 1'b0;
    logic            csr_da = 1'b0;
    logic            csr_pg = 1'b1;
    logic [1:0]      csr_plv = 2'd0;
    logic [1:0]      csr_datm = 2'd0;
    logic [9:0]      csr_asid = 10'h155;
    logic [31:0]     csr_dmw0 = '0;
    logic [31:0]     csr_dmw1 = '0;
    logic            tlb_fetch;
    logic [18:0]     tlb_vppn;
    logic            tlb_odd_page;
    logic [9:0]      tlb_asid;
    logic            tlb_found = 1'b1;
    logic [IDXW-1:0] tlb_index = '0;
    logic [5:0]      tlb_ps = 6'd12;
    logic [19:0]     tlb_ppn = 20'h12345;
    logic            tlb_v = 1'b1;
    logic            tlb_d = 1'b1;
    logic [1:0]      tlb_mat = 2'd1;
    logic [1:0]      tlb_plv = 2'd0;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    addr_xlate_unit #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_vaddr    (req_vaddr),
        .req_op       (req_op),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_paddr   (resp_paddr),
        .resp_mat     (resp_mat),
        .resp_ex      (resp_ex),
        .resp_ecode   (resp_ecode),
        .flush        (flush),
        .csr_da       (csr_da),
        .csr_pg       (csr_pg),
        .csr_plv      (csr_plv),
        .csr_datm     (csr_datm),
        .csr_asid     (csr_asid),
        .csr_dmw0     (csr_dmw0),
        .csr_dmw1     (csr_dmw1),
        .tlb_fetch    (tlb_fetch),
        .tlb_vppn     (tlb_vppn),
        .tlb_odd_page (tlb_odd_page),
        .tlb_asid     (tlb_asid),
        .tlb_found    (tlb_found),
        .tlb_index    (tlb_index),
        .tlb_ps       (tlb_ps),
        .tlb_ppn      (tlb_ppn),
        .tlb_v        (tlb_v),
        .tlb_d        (tlb_d),
        .tlb_mat      (tlb_mat),
        .tlb_plv      (tlb_plv)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pa, input logic [1:0] mat, input logic ex,
                                input logic [5:0] ec);
        exp_t e;
        e.paddr = pa;
        e.mat   = mat;
        e.ex    = ex;
        e.ecode = ec;
        return e;
    endfunction

    // Response monitor: samples 1 time unit before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (resp_valid && resp_ready && !flush && !reset) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_resp", resp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("resp_paddr", resp_paddr, e.paddr);
                    check_eq("resp_mat", 32'(resp_mat), 32'(e.mat));
                    check_eq("resp_ex", 32'(resp_ex), 32'(e.ex));
                    check_eq("resp_ecode", 32'(resp_ecode), 32'(e.ecode));
                end
            end
        end
    end

    // Drive one request, check search port, latency and fetch pulse count.
    task automatic send(input logic [31:0] va, input logic [1:0] op, input exp_t e,
                        input int exp_lat, input int exp_fetch, input int post_plv);
        int lat;
        int fetches;
        exp_q.push_back(e);
        @(negedge clk);
        req_vaddr = va;
        req_op    = op;
        req_valid = 1'b1;
        #1;
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        fetches = int'(tlb_fetch);
        if (tlb_fetch) begin
            check_eq("tlb_vppn", 32'(tlb_vppn), 32'(va[31:13]));
            check_eq("tlb_odd_page", 32'(tlb_odd_page), 32'(va[12]));
            check_eq("tlb_asid", 32'(tlb_asid), 32'(csr_asid));
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (post_plv >= 0) csr_plv = post_plv[1:0];
        lat = 1;
        while (!resp_valid && lat < 8) begin
            fetches += int'(tlb_fetch);
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("tlb_fetch_pulses", fetches, exp_fetch);
        if (resp_ready) begin
            @(posedge clk);
            #1;
            check_eq("resp_drop", 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_tlb_fetch", 32'(tlb_fetch), 32'd0);
        check_eq("rst_paddr", resp_paddr, 32'd0);
        check_eq("rst_mat_ex_ecode", {23'd0, resp_mat, resp_ex, resp_ecode}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // DA mode
        csr_da   = 1'b1;
        csr_datm = 2'd1;
        send(32'h1C00_0100, OP_LOAD, mk(32'h1C00_0100, 2'd1, 1'b0, 6'h00), 1, 0, -1);
        csr_da   = 1'b0;

        // DMW0: vseg=101, pseg=000, mat=1, plv0 enable
        csr_dmw0 = 32'hA000_0011;
        send(32'hA000_1234, OP_LOAD, mk(32'h0000_1234, 2'd1, 1'b0, 6'h00), 1, 0, -1);
        // DMW1: vseg=101, pseg=010, mat=2, plv0+plv3 enable; DMW0 still wins at PLV0
        csr_dmw1 = 32'hA400_0029;
        send(32'hA000_1234, OP_LOAD, mk(32'h0000_1234, 2'd1, 1'b0, 6'h00), 1, 0, -1);
        // PLV3: DMW0 lacks plv3 enable, DMW1 hits
        csr_plv = 2'd3;
        send(32'hA000_1234, OP_FETCH, mk(32'h4000_1234, 2'd2, 1'b0, 6'h00), 1, 0, 0);
        csr_dmw0 = '0;
        csr_dmw1 = '0;

        // TLB 4KB store hit
        send(32'h0040_0ABC, OP_STORE, mk(32'h1234_5ABC, 2'd1, 1'b0, 6'h00), 2, 1, -1);
        // TLB 2MB hit: {ppn[19:9]=11'h005, vaddr[20:0]=21'h123456}
        tlb_ps  = 6'd21;
        tlb_ppn = 20'h00A00;
        send(32'h0012_3456, OP_LOAD, mk(32'h00B2_3456, 2'd1, 1'b0, 6'h00), 2, 1, -1);
        tlb_ps  = 6'd12;
        tlb_ppn = 20'h12345;

        // Exceptions
        tlb_found = 1'b0;
        send(32'h0040_0ABC, OP_LOAD, mk(32'h1234_5ABC, 2'd1, 1'b1, ECODE_TLBR), 2, 1, -1);
        tlb_found = 1'b1;
        tlb_v = 1'b0;
        send(32'h0040_0ABC, OP_FETCH, mk(32'h1234_5ABC, 2'd1, 1'b1, ECODE_PIF), 2, 1, -1);
        tlb_v = 1'b1;
        // PLV3 vs entry PLV0; PLV dropped right after accept must not matter
        csr_plv = 2'd3;
        send(32'h0040_0ABC, OP_LOAD, mk(32'h1234_5ABC, 2'd1, 1'b1, ECODE_PPI), 2, 1, 0);
        tlb_d = 1'b0;
        send(32'h0040_1ABC, OP_STORE, mk(32'h1234_5ABC, 2'd1, 1'b1, ECODE_PME), 2, 1, -1);
        tlb_d = 1'b1;
        // Invalid page outranks PLV violation
        tlb_v   = 1'b0;
        csr_plv = 2'd3;
        send(32'h0040_0ABC, OP_LOAD, mk(32'h1234_5ABC, 2'd1, 1'b1, ECODE_PIL), 2, 1, -1);
        send(32'h0040_0ABC, OP_STORE, mk(32'h1234_5ABC, 2'd1, 1'b1, ECODE_PIS), 2, 1, 0);
        tlb_v = 1'b1;

        // Backpressure: outputs hold while TLB/CSR inputs wander
        resp_ready = 1'b0;
        send(32'h0040_0ABC, OP_LOAD, mk(32'h1234_5ABC, 2'd1, 1'b0, 6'h00), 2, 1, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tlb_ppn  = 20'h54321 + 20'(i);
            csr_datm = 2'(i);
            #4;
            check_eq("bp_resp_valid", 32'(resp_valid), 32'd1);
            check_eq("bp_req_ready", 32'(req_ready), 32'd0);
            check_eq("bp_paddr", resp_paddr, 32'h1234_5ABC);
            check_eq("bp_ex_ecode", {25'd0, resp_ex, resp_ecode}, 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        tlb_ppn    = 20'h12345;
        @(posedge clk);
        #1;
        check_eq("bp_release", 32'(resp_valid), 32'd0);

        // Flush during LOOKUP
        @(negedge clk);
        req_vaddr = 32'h0040_0ABC;
        req_op    = OP_LOAD;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("lookup_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_lookup_idle", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check_eq("flush_lookup_no_resp", 32'(resp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        send(32'h0040_0ABC, OP_STORE, mk(32'h1234_5ABC, 2'd1, 1'b0, 6'h00), 2, 1, -1);

        // Flush in the accept cycle cancels the request and the search
        @(negedge clk);
        req_vaddr = 32'h0040_0ABC;
        req_valid = 1'b1;
        flush     = 1'b1;
        #1;
        check_eq("flush_accept_no_fetch", 32'(tlb_fetch), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check_eq("flush_accept_idle", 32'(req_ready), 32'd1);
        check_eq("flush_accept_no_resp", 32'(resp_valid), 32'd0);

        // Flush wins over resp_ready in RESP
        csr_da = 1'b1;
        @(negedge clk);
        req_vaddr = 32'h0000_2000;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("flush_resp_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_resp_drop", 32'(resp_valid), 32'd0);

        // Reset while holding a response
        resp_ready = 1'b0;
        @(negedge clk);
        req_vaddr = 32'h0000_3000;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("reset_pre_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("reset_paddr", resp_paddr, 32'd0);
        check_eq("reset_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset      = 1'b0;
        resp_ready = 1'b1;
        csr_datm   = 2'd2;
        send(32'h0000_4000, OP_LOAD, mk(32'h0000_4000, 2'd2, 1'b0, 6'h00), 1, 0, -1);
        csr_da = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
